// File: rtl/aes128_inv_cipher.sv
// Iterative AES-128 decryption core (InvCipher), one round per clock, round keys generated backwards on the fly.
// Latency: 10 edges from accept to valid (round key 10 supplied or cached), 20 edges when forward key expansion runs first.
// Backpressure: single block in flight; InReady_SO only in IDLE, result held in DONE until OutReady_SI.
module aes128_inv_cipher #(
  parameter int unsigned KEY_IS_LAST = 0
) (
  input  logic         Clk_CI,
  input  logic         Rst_RI,
  input  logic         InValid_SI,
  output logic         InReady_SO,
  input  logic [127:0] Ciphertext_DI,
  input  logic [127:0] Key_DI,
  input  logic         KeyReuse_SI,
  output logic         OutValid_SO,
  input  logic         OutReady_SI,
  output logic [127:0] Plaintext_DO
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} state_e;

  // Byte b of each table sits at bits [8*(255-b)+7 -: 8].
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    return INV_SBOX[{~b, 3'b111} -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // Row r of the state rotates right by r columns.
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(4*((c+r)%4)+r) -: 8] = s[127-8*(4*c+r) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      o[127-8*k -: 8] = inv_sbox(s[127-8*k -: 8]);
    end
    return o;
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] x2, x4, x8;
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int r = 0; r < 4; r++) begin
      a[r]  = col[31-8*r -: 8];
      x2    = xtime(a[r]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[r] = x8 ^ a[r];
      mb[r] = x8 ^ x2 ^ a[r];
      md[r] = x8 ^ x4 ^ a[r];
      me[r] = x8 ^ x4 ^ x2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, rk_q, cache_q;
  logic [3:0]   cnt_q;
  logic         cache_vld_q;
  logic         accept, use_cache;
  logic [31:0]  sub_in, sub_out;
  logic [127:0] rk_fwd, rk_inv, round_t, round_mix;

  assign InReady_SO = (state_q == IDLE) && !Rst_RI;
  assign accept     = InValid_SI && InReady_SO;
  assign use_cache  = (KEY_IS_LAST == 0) && KeyReuse_SI && cache_vld_q;

  // One shared SubWord serves both key directions: forward uses w3, inverse uses the new w3 (w3^w2).
  assign sub_in  = (state_q == KEYEXP) ? rk_q[31:0] : (rk_q[31:0] ^ rk_q[63:32]);
  assign sub_out = sub_word({sub_in[23:0], sub_in[31:24]}) ^ {rcon(cnt_q), 24'h0};

  // Next/previous round key and one inverse round of the state.
  always_comb begin
    rk_fwd = '0;
    rk_inv = '0;
    rk_fwd[127:96] = rk_q[127:96] ^ sub_out;
    rk_fwd[95:64]  = rk_q[95:64] ^ rk_fwd[127:96];
    rk_fwd[63:32]  = rk_q[63:32] ^ rk_fwd[95:64];
    rk_fwd[31:0]   = rk_q[31:0]  ^ rk_fwd[63:32];
    rk_inv[31:0]   = rk_q[31:0]  ^ rk_q[63:32];
    rk_inv[63:32]  = rk_q[63:32] ^ rk_q[95:64];
    rk_inv[95:64]  = rk_q[95:64] ^ rk_q[127:96];
    rk_inv[127:96] = rk_q[127:96] ^ sub_out;
    round_t   = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_inv;
    round_mix = inv_mix_columns(round_t);
  end

  // FSM state register.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ((KEY_IS_LAST != 0) || use_cache) ? ROUND : KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10) state_d = ROUND;
      ROUND:   if (cnt_q == 4'd1) state_d = DONE;
      DONE:    if (OutReady_SI) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: state, round key, counter, key cache and output register.
  always_ff @(posedge Clk_CI) begin
    if (Rst_RI) begin
      st_q         <= '0;
      rk_q         <= '0;
      cnt_q        <= '0;
      cache_q      <= '0;
      cache_vld_q  <= 1'b0;
      OutValid_SO  <= 1'b0;
      Plaintext_DO <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (KEY_IS_LAST != 0) begin
              st_q  <= Ciphertext_DI ^ Key_DI;
              rk_q  <= Key_DI;
              cnt_q <= 4'd10;
            end else if (use_cache) begin
              st_q  <= Ciphertext_DI ^ cache_q;
              rk_q  <= cache_q;
              cnt_q <= 4'd10;
            end else begin
              st_q  <= Ciphertext_DI;
              rk_q  <= Key_DI;
              cnt_q <= 4'd1;
            end
          end
        end
        KEYEXP: begin
          rk_q <= rk_fwd;
          if (cnt_q == 4'd10) begin
            st_q        <= st_q ^ rk_fwd;
            cache_q     <= rk_fwd;
            cache_vld_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          rk_q  <= rk_inv;
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            st_q         <= round_t;
            Plaintext_DO <= round_t;
            OutValid_SO  <= 1'b1;
          end else begin
            st_q <= round_mix;
          end
        end
        DONE: begin
          if (OutReady_SI) OutValid_SO <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes128_inv_cipher.sv
module tb_aes128_inv_cipher;

  localparam logic [127:0] K1   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] RK10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] K2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  logic         clk = 1'b0;
  logic         rst, ivld0, ivld1, reuse, ordy;
  logic [127:0] ct, key;
  logic         irdy0, ovld0, irdy1, ovld1;
  logic [127:0] pt0, pt1;
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [7:0]   sb  [256];
  logic [7:0]   isb [256];

  always #5 clk = ~clk;

  aes128_inv_cipher #(.KEY_IS_LAST(0)) u0 (
    .Clk_CI(clk), .Rst_RI(rst), .InValid_SI(ivld0), .InReady_SO(irdy0),
    .Ciphertext_DI(ct), .Key_DI(key), .KeyReuse_SI(reuse),
    .OutValid_SO(ovld0), .OutReady_SI(ordy), .Plaintext_DO(pt0));

  aes128_inv_cipher #(.KEY_IS_LAST(1)) u1 (
    .Clk_CI(clk), .Rst_RI(rst), .InValid_SI(ivld1), .InReady_SO(irdy1),
    .Ciphertext_DI(ct), .Key_DI(key), .KeyReuse_SI(reuse),
    .OutValid_SO(ovld1), .OutReady_SI(ordy), .Plaintext_DO(pt1));

  // ---------------- reference model (GF arithmetic, byte-matrix state) ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xt(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w [4];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    t = {w[3][23:0], w[3][31:24]};
    t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
    w[0] = w[0] ^ t;
    w[1] = w[1] ^ w[0];
    w[2] = w[2] ^ w[1];
    w[3] = w[3] ^ w[2];
    return {w[0], w[1], w[2], w[3]};
  endfunction

  function automatic logic [127:0] model_rk10(input logic [127:0] k);
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 10; i++) begin
      k  = next_key(k, rc);
      rc = xt(rc);
    end
    return k;
  endfunction

  function automatic logic [127:0] model_dec(input logic [127:0] cin, input logic [127:0] k);
    logic [127:0] rk [11];
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   a [4];
    logic [7:0]   rc = 8'h01;
    logic [127:0] o = '0;
    rk[0] = k;
    for (int i = 1; i < 11; i++) begin
      rk[i] = next_key(rk[i-1], rc);
      rc    = xt(rc);
    end
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++)
        s[r][col] = cin[127-8*(4*col+r) -: 8] ^ rk[10][127-8*(4*col+r) -: 8];
    for (int rnd = 9; rnd >= 0; rnd--) begin
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          t[r][(col+r)%4] = isb[s[r][col]];
      for (int r = 0; r < 4; r++)
        for (int col = 0; col < 4; col++)
          s[r][col] = t[r][col] ^ rk[rnd][127-8*(4*col+r) -: 8];
      if (rnd > 0) begin
        for (int col = 0; col < 4; col++) begin
          for (int r = 0; r < 4; r++) a[r] = s[r][col];
          s[0][col] = gm(a[0], 8'd14) ^ gm(a[1], 8'd11) ^ gm(a[2], 8'd13) ^ gm(a[3], 8'd9);
          s[1][col] = gm(a[0], 8'd9)  ^ gm(a[1], 8'd14) ^ gm(a[2], 8'd11) ^ gm(a[3], 8'd13);
          s[2][col] = gm(a[0], 8'd13) ^ gm(a[1], 8'd9)  ^ gm(a[2], 8'd14) ^ gm(a[3], 8'd11);
          s[3][col] = gm(a[0], 8'd11) ^ gm(a[1], 8'd13) ^ gm(a[2], 8'd9)  ^ gm(a[3], 8'd14);
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int col = 0; col < 4; col++)
        o[127-8*(4*col+r) -: 8] = s[r][col];
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; ivld0 = 1'b0; ivld1 = 1'b0; ordy = 1'b0; reuse = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rdy_in_reset", 128'(irdy0), 128'(1'b0));
    rst = 1'b0;
    #1;
    check("rst_rdy0", 128'(irdy0), 128'(1'b1));
    check("rst_vld0", 128'(ovld0), 128'(1'b0));
    check("rst_pt0", pt0, 128'h0);
    check("rst_rdy1", 128'(irdy1), 128'(1'b1));
    check("rst_vld1", 128'(ovld1), 128'(1'b0));
    check("rst_pt1", pt1, 128'h0);
  endtask

  // One block: accept, scramble inputs while busy (optionally pulsing valid), measure latency,
  // optionally stall the sink, then handshake and confirm the result is held.
  task automatic run_block(input bit sel, input logic [127:0] c, input logic [127:0] k,
                           input bit ru, input logic [127:0] exp_pt, input int exp_lat,
                           input int stall, input int glitch_at, input string tag);
    int   edges;
    logic seen;
    @(negedge clk);
    ct = c; key = k; reuse = ru;
    if (sel) ivld1 = 1'b1; else ivld0 = 1'b1;
    check({tag, "_inrdy"}, 128'(sel ? irdy1 : irdy0), 128'(1'b1));
    @(posedge clk);
    @(negedge clk);
    ivld0 = 1'b0; ivld1 = 1'b0;
    edges = 0;
    seen  = sel ? ovld1 : ovld0;
    while (!seen && edges < 40) begin
      ct = rnd128(); key = rnd128(); reuse = 1'($urandom);
      if (sel) ivld1 = (edges == glitch_at); else ivld0 = (edges == glitch_at);
      @(posedge clk);
      edges++;
      @(negedge clk);
      seen = sel ? ovld1 : ovld0;
    end
    ivld0 = 1'b0; ivld1 = 1'b0;
    check({tag, "_latency"}, 128'(edges), 128'(exp_lat));
    check({tag, "_pt"}, sel ? pt1 : pt0, exp_pt);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, "_stall_vld"}, 128'(sel ? ovld1 : ovld0), 128'(1'b1));
      check({tag, "_stall_pt"}, sel ? pt1 : pt0, exp_pt);
      check({tag, "_stall_rdy"}, 128'(sel ? irdy1 : irdy0), 128'(1'b0));
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    check({tag, "_vld_drop"}, 128'(sel ? ovld1 : ovld0), 128'(1'b0));
    check({tag, "_rdy_back"}, 128'(sel ? irdy1 : irdy0), 128'(1'b1));
    check({tag, "_pt_hold"}, sel ? pt1 : pt0, exp_pt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0]   inv;
    logic [7:0]   aff;
    logic [127:0] rk, c, c2;
    rst = 1'b1; ivld0 = 1'b0; ivld1 = 1'b0; reuse = 1'b0; ordy = 1'b0;
    ct = '0; key = '0;

    // Build S-boxes from the field inverse plus affine map.
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      aff = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x]   = aff;
      isb[aff] = 8'(x);
    end

    do_reset();

    // Known-answer blocks, full key expansion path.
    run_block(1'b0, CT1, K1, 1'b0, PT1, 20, 0, 12, "t1");
    run_block(1'b0, CT2, K2, 1'b0, PT2, 20, 0, 12, "t2");
    // Cache hit: Key_DI ignored.
    run_block(1'b0, CT2, 128'h0, 1'b1, PT2, 10, 0, 5, "t3_hit");
    // After reset the cache is gone, so key 0 is expanded and used.
    do_reset();
    run_block(1'b0, CT2, 128'h0, 1'b1, model_dec(CT2, 128'h0), 20, 0, 12, "t3_miss");

    // Round key 10 supplied directly; reuse flag has no effect.
    run_block(1'b1, CT1, RK10, 1'b0, PT1, 10, 0, 5, "t4");
    run_block(1'b1, CT1, RK10, 1'b1, PT1, 10, 0, 5, "t4_reuse");

    // Sink stalls five cycles in DONE, valid pulse mid-round ignored.
    run_block(1'b0, CT1, K1, 1'b0, PT1, 20, 5, 13, "t5");

    // Reset for one cycle during ROUND.
    @(negedge clk);
    ct = CT1; key = K1; reuse = 1'b0; ivld0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ivld0 = 1'b0;
    repeat (13) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t6_rdy", 128'(irdy0), 128'(1'b1));
    check("t6_vld", 128'(ovld0), 128'(1'b0));
    check("t6_pt", pt0, 128'h0);
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("t6_no_vld", 128'(ovld0), 128'(1'b0));
    run_block(1'b0, CT1, K1, 1'b1, PT1, 20, 0, 8, "t6_rerun");

    // Random keys and ciphertexts against the model.
    for (int i = 0; i < 6; i++) begin
      rk = rnd128();
      c  = rnd128();
      c2 = rnd128();
      run_block(1'b0, c, rk, 1'b0, model_dec(c, rk), 20, i % 2, 12, "rnd_exp");
      run_block(1'b0, c2, rnd128(), 1'b1, model_dec(c2, rk), 10, 0, 5, "rnd_hit");
      run_block(1'b1, c2, model_rk10(rk), 1'($urandom), model_dec(c2, rk), 10, 0, 5, "rnd_last");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
